entrada_senha: RTL and testbench
================================

// Module: entrada_senha
// PURPOSE
//  Code-entry sequencer for the bomb defuse path; sits directly upstream of the 4-bit digit comparator.
//  - Collects N_DIGITOS keypad digits and, on confirm, walks them one per cycle.
//  - Drives each entered/reference digit pair plus enable into the comparator and folds the returned match bit.
//  - Declares defused (acerto) or counts a failed attempt; locks after MAX_TENTATIVAS failures.
// PARAMETERS
//  N_DIGITOS       4  digits per code (>=1)
//  MAX_TENTATIVAS  3  failed attempts before lock (>=1)
// PORTS
//  clk           in   1          single system clock, all state on rising edge
//  reset         in   1          synchronous, active-high
//  digito        in   4          keypad digit value (0-15, no range check)
//  digito_valido in   1          1-cycle strobe: digito is valid
//  confirma      in   1          1-cycle strobe: submit entered code
//  senha_ref     in   4*N        reference code; digit i = senha_ref[4*i+:4]; must be stable while comparing
//  q1            out  4          entered digit to comparator
//  q2            out  4          reference digit to comparator
//  en_cmp        out  1          comparator enable
//  s_cmp         in   1          comparator match (combinational, same cycle)
//  digitos_lidos out  clog2(N+1) digits captured in current attempt
//  tentativas    out  clog2(MAX+1) failed attempts so far
//  erro          out  1          1-cycle pulse: attempt failed, not locked
//  acerto        out  1          sticky: code correct
//  bloqueado     out  1          sticky: attempts exhausted
// BEHAVIOUR
//  Reset: all outputs 0, state CAPTURA, buffer cleared. reset overrides everything, any state, mid-compare included.
//  CAPTURA:
//   - digito_valido with digitos_lidos<N: buf[digitos_lidos]<=digito, count+1.
//   - Strobes at count==N are ignored.
//   - confirma: if count==N -> COMPARA, cmp_idx=0, ok=1. If count<N -> RESULTADO with ok=0 (short code = wrong).
//   - confirma and digito_valido in the same cycle: confirma wins, digit discarded.
//  COMPARA:
//   - Lasts exactly N cycles. In each cycle: en_cmp=1, q1=buf[cmp_idx], q2=senha_ref[4*cmp_idx+:4].
//   - ok<=ok&s_cmp; cmp_idx+1. After cmp_idx==N-1 -> RESULTADO.
//   - No early exit on mismatch, so timing does not leak the failing position.
//   - Keypad strobes are ignored.
//  RESULTADO (1 cycle, en_cmp=0):
//   - ok=1 -> ABERTO, acerto<=1.
//   - ok=0 and tentativas+1==MAX -> BLOQUEADO; tentativas<=MAX; bloqueado<=1; no erro pulse.
//   - ok=0 otherwise -> tentativas+1, erro=1 for this cycle, clear buffer and count, -> CAPTURA.
//  ABERTO / BLOQUEADO: terminal until reset; all inputs ignored; en_cmp=0, q1=q2=0.
//  Latency: confirma (full code) -> acerto/erro/bloqueado = N+1 cycles. Short-code confirma -> 1 cycle.
//  Outside COMPARA: en_cmp=0, q1=q2=0. Comparator output is don't-care.
//  Digit order: first entered digit is compared against senha_ref[3:0].
// STRUCTURE
//  entrada_senha_pkg:
//   - typedef enum logic [2:0] {CAPTURA, COMPARA, RESULTADO, ABERTO, BLOQUEADO} estado_t
//   - localparam DIGITO_W=4
//  Sub-module registro_digitos: N x 4-bit write-indexed buffer with clear and read mux.
//  FSM, counters and ok flag live in the top.
//  The bench instantiates the comparator alongside the block and ties q1/q2/en_cmp -> s_cmp.
// TESTING (N=4, MAX=3, senha_ref=16'h4321, i.e. enter 1,2,3,4)
//  1 Correct code:
//   - Stimulus: enter 1,2,3,4, then confirma.
//   - Response: en_cmp high 4 cycles with q1/q2 = 1/1, 2/2, 3/3, 4/4; acerto=1 at cycle 5; erro never; tentativas=0.
//  2 Wrong last digit:
//   - Stimulus: enter 1,2,3,5, then confirma.
//   - Response: still 4 compare cycles; erro pulse; tentativas=1; digitos_lidos=0.
//  3 Lock-out:
//   - Stimulus: three wrong full codes.
//   - Response: erro pulses twice; third attempt -> bloqueado=1, tentativas=3, no erro.
//   - Response after lock: a correct code is ignored, acerto stays 0.
//  4 Short code and overflow:
//   - Stimulus: enter 1,2 then confirma.
//   - Response: erro next cycle, tentativas=1, no en_cmp.
//   - Stimulus: then enter 1,2,3,4,9.
//   - Response: 9 ignored, digitos_lidos=4; confirma -> acerto.
//  5 Collision:
//   - Stimulus: digito_valido (digit 4) and confirma in the same cycle, with count=3.
//   - Response: digit dropped; short code -> erro.
//  6 Reset mid-compare:
//   - Stimulus: assert reset in the 2nd COMPARA cycle.
//   - Response: next cycle all outputs 0, state CAPTURA; a fresh correct entry gives acerto.

Source files
------------

// File: rtl/entrada_senha_pkg.sv
// Shared types and constants for the code-entry sequencer.
package entrada_senha_pkg;

    localparam int DIGITO_W = 4;

    typedef enum logic [2:0] {
        CAPTURA,
        COMPARA,
        RESULTADO,
        ABERTO,
        BLOQUEADO
    } estado_t;

    // Width of an index into n digits; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/entrada_senha_registro_digitos.sv
// Digit buffer: N_DIGITOS x 4-bit entries, written by index, cleared
// in one cycle, read through a combinational mux.
module registro_digitos
    import entrada_senha_pkg::*;
#(
    parameter int N_DIGITOS = 4,
    parameter int IW        = idx_w(N_DIGITOS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                limpa,
    input  logic                escreve,
    input  logic [IW-1:0]       idx_esc,
    input  logic [DIGITO_W-1:0] d,
    input  logic [IW-1:0]       idx_le,
    output logic [DIGITO_W-1:0] q
);

    logic [DIGITO_W-1:0] mem [N_DIGITOS];

    // Storage: reset or clear wipes every entry, otherwise write the addressed one.
    always_ff @(posedge clk) begin
        if (reset || limpa) begin
            for (int i = 0; i < N_DIGITOS; i++) begin
                mem[i] <= '0;
            end
        end else if (escreve) begin
            mem[idx_esc] <= d;
        end
    end

    // Read mux feeding the comparator's entered-digit lane.
    always_comb begin
        q = mem[idx_le];
    end

endmodule

// File: rtl/entrada_senha.sv
// Code-entry sequencer for the defuse path. Captures N_DIGITOS keypad
// digits, then on confirm walks them one per cycle through an external
// combinational comparator and folds the match bits into a verdict.
//
// Interface semantics: digito_valido and confirma are single-cycle
// strobes with no back-pressure; a strobe that arrives while the block
// cannot use it (full buffer, comparing, terminal state) is dropped.
// en_cmp qualifies q1/q2, and s_cmp is sampled only while en_cmp is high.
module entrada_senha
    import entrada_senha_pkg::*;
#(
    parameter int N_DIGITOS      = 4,
    parameter int MAX_TENTATIVAS = 3
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [DIGITO_W-1:0]                   digito,
    input  logic                                  digito_valido,
    input  logic                                  confirma,
    input  logic [DIGITO_W*N_DIGITOS-1:0]         senha_ref,
    output logic [DIGITO_W-1:0]                   q1,
    output logic [DIGITO_W-1:0]                   q2,
    output logic                                  en_cmp,
    input  logic                                  s_cmp,
    output logic [$clog2(N_DIGITOS+1)-1:0]        digitos_lidos,
    output logic [$clog2(MAX_TENTATIVAS+1)-1:0]   tentativas,
    output logic                                  erro,
    output logic                                  acerto,
    output logic                                  bloqueado,
    output estado_t                               estado
);

    localparam int CW = $clog2(N_DIGITOS + 1);
    localparam int TW = $clog2(MAX_TENTATIVAS + 1);
    localparam int IW = idx_w(N_DIGITOS);

    localparam logic [CW-1:0] CNT_CHEIO = CW'(N_DIGITOS);
    localparam logic [IW-1:0] IDX_ULT   = IW'(N_DIGITOS - 1);
    localparam logic [TW-1:0] TENT_ULT  = TW'(MAX_TENTATIVAS - 1);
    localparam logic [TW-1:0] TENT_MAX  = TW'(MAX_TENTATIVAS);

    estado_t estado_q, estado_d;

    logic [CW-1:0]       cnt;
    logic [IW-1:0]       cmp_idx;
    logic [TW-1:0]       tent;
    logic                ok;
    logic                erro_q;
    logic                acerto_q;
    logic                bloq_q;

    logic                cheio;
    logic                ultimo;
    logic                falha_final;
    logic                escreve;
    logic                limpa;
    logic [DIGITO_W-1:0] buf_q;
    logic [DIGITO_W-1:0] ref_dig [N_DIGITOS];

    assign cheio       = (cnt == CNT_CHEIO);
    assign ultimo      = (cmp_idx == IDX_ULT);
    assign falha_final = (tent == TENT_ULT);

    // confirma has priority over a digit strobe in the same cycle.
    assign escreve = (estado_q == CAPTURA) && digito_valido && !confirma && !cheio;
    // A failed, non-locking verdict starts a fresh attempt with an empty buffer.
    assign limpa   = (estado_q == RESULTADO) && !ok && !falha_final;

    // Reference digit i lives at senha_ref[4*i +: 4]; first entered digit pairs with digit 0.
    for (genvar g = 0; g < N_DIGITOS; g++) begin : g_ref
        assign ref_dig[g] = senha_ref[DIGITO_W*g +: DIGITO_W];
    end

    registro_digitos #(
        .N_DIGITOS (N_DIGITOS),
        .IW        (IW)
    ) u_registro (
        .clk     (clk),
        .reset   (reset),
        .limpa   (limpa),
        .escreve (escreve),
        .idx_esc (cnt[IW-1:0]),
        .d       (digito),
        .idx_le  (cmp_idx),
        .q       (buf_q)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= CAPTURA;
        end else begin
            estado_q <= estado_d;
        end
    end

    // Next-state logic and comparator drive; the comparator lanes are zero outside COMPARA.
    always_comb begin
        estado_d = estado_q;
        en_cmp   = 1'b0;
        q1       = '0;
        q2       = '0;
        case (estado_q)
            CAPTURA: begin
                if (confirma) begin
                    estado_d = cheio ? COMPARA : RESULTADO;
                end
            end
            COMPARA: begin
                en_cmp = 1'b1;
                q1     = buf_q;
                q2     = ref_dig[cmp_idx];
                // Always walk every digit so timing does not reveal the first mismatch.
                if (ultimo) begin
                    estado_d = RESULTADO;
                end
            end
            RESULTADO: begin
                if (ok) begin
                    estado_d = ABERTO;
                end else if (falha_final) begin
                    estado_d = BLOQUEADO;
                end else begin
                    estado_d = CAPTURA;
                end
            end
            ABERTO:    estado_d = ABERTO;
            BLOQUEADO: estado_d = BLOQUEADO;
            default:   estado_d = CAPTURA;
        endcase
    end

    // Datapath: digit count, compare index, match fold, attempt counter and verdict flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            cmp_idx  <= '0;
            tent     <= '0;
            ok       <= 1'b0;
            erro_q   <= 1'b0;
            acerto_q <= 1'b0;
            bloq_q   <= 1'b0;
        end else begin
            erro_q <= 1'b0;
            case (estado_q)
                CAPTURA: begin
                    if (confirma) begin
                        cmp_idx <= '0;
                        // A short code goes straight to the verdict as a mismatch.
                        ok      <= cheio;
                    end else if (digito_valido && !cheio) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                COMPARA: begin
                    ok      <= ok & s_cmp;
                    cmp_idx <= ultimo ? '0 : cmp_idx + IW'(1);
                end
                RESULTADO: begin
                    if (ok) begin
                        acerto_q <= 1'b1;
                    end else if (falha_final) begin
                        tent   <= TENT_MAX;
                        bloq_q <= 1'b1;
                    end else begin
                        tent   <= tent + TW'(1);
                        erro_q <= 1'b1;
                        cnt    <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign digitos_lidos = cnt;
    assign tentativas    = tent;
    assign erro          = erro_q;
    assign acerto        = acerto_q;
    assign bloqueado     = bloq_q;
    assign estado        = estado_q;

endmodule

// File: tb/tb_entrada_senha.sv
// Bench for entrada_senha: directed table, hand-written corner sequences
// and randomized attempts checked against an attempt-level model.
module tb_entrada_senha;
  import entrada_senha_pkg::*;

  localparam int N   = 4;
  localparam int MAX = 3;
  localparam int BUD = 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic [3:0]    digito = '0;
  logic          digito_valido = 1'b0;
  logic          confirma = 1'b0;
  logic [15:0]   senha_ref = 16'h4321;
  logic [3:0]    q1, q2;
  logic          en_cmp, s_cmp;
  logic [2:0]    digitos_lidos;
  logic [1:0]    tentativas;
  logic          erro, acerto, bloqueado;
  estado_t       estado;

  // Digit comparator sitting next to the block.
  assign s_cmp = en_cmp && (q1 == q2);

  entrada_senha #(.N_DIGITOS(N), .MAX_TENTATIVAS(MAX)) dut (
    .clk(clk), .reset(reset), .digito(digito), .digito_valido(digito_valido),
    .confirma(confirma), .senha_ref(senha_ref), .q1(q1), .q2(q2), .en_cmp(en_cmp),
    .s_cmp(s_cmp), .digitos_lidos(digitos_lidos), .tentativas(tentativas),
    .erro(erro), .acerto(acerto), .bloqueado(bloqueado), .estado(estado)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nome, act, exp);
    end
  endtask

  // Inputs set before step() are sampled at its rising edge; outputs read 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model (attempt level) ----------------
  int mq[$];
  int m_fails;
  bit m_aberto, m_bloq;

  function automatic int ref_dig(input int j);
    return int'((senha_ref >> (4 * j)) & 16'hF);
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    digito_valido = 1'b0;
    confirma = 1'b0;
    step();
    reset = 1'b0;
    mq.delete();
    m_fails  = 0;
    m_aberto = 1'b0;
    m_bloq   = 1'b0;
  endtask

  task automatic entra(input logic [3:0] d);
    digito = d;
    digito_valido = 1'b1;
    step();
    digito_valido = 1'b0;
  endtask

  // One full attempt: n digits (the last one colliding with confirma when col=1),
  // then confirm, watch the compare walk and check the verdict against the model.
  task automatic tentativa(input string nome, input int n, input logic [3:0] ds [8], input bit col);
    int  n_ent, en_cnt, lat, k;
    bit  term, full, certo;
    n_ent  = col ? n - 1 : n;
    en_cnt = 0;
    lat    = -1;
    k      = 0;
    term   = m_aberto || m_bloq;
    for (int i = 0; i < n_ent; i++) begin
      entra(ds[i]);
      if (!term && mq.size() < N) mq.push_back(int'(ds[i]));
    end
    full  = (mq.size() == N);
    certo = full;
    for (int j = 0; j < mq.size(); j++) if (mq[j] != ref_dig(j)) certo = 1'b0;

    digito        = col ? ds[n-1] : 4'd0;
    digito_valido = col;
    confirma      = 1'b1;
    step();
    confirma      = 1'b0;
    digito_valido = 1'b0;

    for (int c = 0; c <= BUD; c++) begin
      if (c > 0) step();
      if (en_cmp) begin
        en_cnt++;
        if (k < mq.size()) begin
          chk({nome, ".q1"}, q1, mq[k]);
          chk({nome, ".q2"}, q2, ref_dig(k));
        end
        k++;
      end else begin
        chk({nome, ".q_idle"}, {q1, q2}, 8'h00);
      end
      if (erro || (acerto && !m_aberto) || (bloqueado && !m_bloq)) begin
        lat = c;
        break;
      end
    end

    if (term) begin
      chk({nome, ".lat"}, lat, -1);
      chk({nome, ".en_cnt"}, en_cnt, 0);
    end else begin
      chk({nome, ".lat"}, lat, full ? N + 1 : 1);
      chk({nome, ".en_cnt"}, en_cnt, full ? N : 0);
      if (certo) begin
        m_aberto = 1'b1;
      end else begin
        m_fails++;
        if (m_fails == MAX) m_bloq = 1'b1;
        else mq.delete();
      end
      chk({nome, ".erro"}, erro, !certo && !m_bloq);
    end
    chk({nome, ".acerto"}, acerto, m_aberto);
    chk({nome, ".bloq"}, bloqueado, m_bloq);
    chk({nome, ".tent"}, tentativas, m_fails);
    chk({nome, ".lidos"}, digitos_lidos, mq.size());
    step();
    chk({nome, ".erro_pulse"}, erro, 1'b0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       rst, dv, cf;
    logic [3:0] dig;
    logic       en;
    logic [3:0] eq1, eq2;
    int         lidos, tent;
    logic       er, ac, bl;
  } vec_t;

  vec_t tab[$];

  task automatic row(input logic rst, input logic dv, input logic [3:0] dig, input logic cf,
                     input logic en, input logic [3:0] eq1, input logic [3:0] eq2,
                     input int lidos, input int tent, input logic er, input logic ac, input logic bl);
    vec_t v;
    v = '{rst: rst, dv: dv, cf: cf, dig: dig, en: en, eq1: eq1, eq2: eq2,
          lidos: lidos, tent: tent, er: er, ac: ac, bl: bl};
    tab.push_back(v);
  endtask

  logic [3:0] ds [8];

  initial begin
    step();
    step();

    // Test 1: correct code 1,2,3,4 -> four compare cycles, acerto 5 cycles after confirma.
    row(1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    row(0, 1, 1, 0,  0, 0, 0, 1, 0, 0, 0, 0);
    row(0, 1, 2, 0,  0, 0, 0, 2, 0, 0, 0, 0);
    row(0, 1, 3, 0,  0, 0, 0, 3, 0, 0, 0, 0);
    row(0, 1, 4, 0,  0, 0, 0, 4, 0, 0, 0, 0);
    row(0, 0, 0, 1,  1, 1, 1, 4, 0, 0, 0, 0);
    row(0, 0, 0, 0,  1, 2, 2, 4, 0, 0, 0, 0);
    row(0, 0, 0, 0,  1, 3, 3, 4, 0, 0, 0, 0);
    row(0, 0, 0, 0,  1, 4, 4, 4, 0, 0, 0, 0);
    row(0, 0, 0, 0,  0, 0, 0, 4, 0, 0, 0, 0);
    row(0, 0, 0, 0,  0, 0, 0, 4, 0, 0, 1, 0);
    row(0, 1, 7, 1,  0, 0, 0, 4, 0, 0, 1, 0);
    // Test 2: wrong last digit -> full walk, erro pulse, tentativas 1, buffer cleared.
    row(1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    row(0, 1, 1, 0,  0, 0, 0, 1, 0, 0, 0, 0);
    row(0, 1, 2, 0,  0, 0, 0, 2, 0, 0, 0, 0);
    row(0, 1, 3, 0,  0, 0, 0, 3, 0, 0, 0, 0);
    row(0, 1, 5, 0,  0, 0, 0, 4, 0, 0, 0, 0);
    row(0, 0, 0, 1,  1, 1, 1, 4, 0, 0, 0, 0);
    row(0, 0, 0, 0,  1, 2, 2, 4, 0, 0, 0, 0);
    row(0, 0, 0, 0,  1, 3, 3, 4, 0, 0, 0, 0);
    row(0, 0, 0, 0,  1, 5, 4, 4, 0, 0, 0, 0);
    row(0, 0, 0, 0,  0, 0, 0, 4, 0, 0, 0, 0);
    row(0, 0, 0, 0,  0, 0, 0, 0, 1, 1, 0, 0);
    row(0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 0);

    for (int i = 0; i < tab.size(); i++) begin
      reset         = tab[i].rst;
      digito_valido = tab[i].dv;
      digito        = tab[i].dig;
      confirma      = tab[i].cf;
      step();
      chk($sformatf("tab%0d.en", i), en_cmp, tab[i].en);
      chk($sformatf("tab%0d.q1", i), q1, tab[i].eq1);
      chk($sformatf("tab%0d.q2", i), q2, tab[i].eq2);
      chk($sformatf("tab%0d.lidos", i), digitos_lidos, tab[i].lidos);
      chk($sformatf("tab%0d.tent", i), tentativas, tab[i].tent);
      chk($sformatf("tab%0d.erro", i), erro, tab[i].er);
      chk($sformatf("tab%0d.acerto", i), acerto, tab[i].ac);
      chk($sformatf("tab%0d.bloq", i), bloqueado, tab[i].bl);
      if (tab[i].rst) chk($sformatf("tab%0d.estado", i), estado, CAPTURA);
    end
    reset = 1'b0;
    digito_valido = 1'b0;
    confirma = 1'b0;

    // Test 3: lock-out after three wrong codes; a correct code afterwards is ignored.
    do_reset();
    ds[0] = 1; ds[1] = 2; ds[2] = 3; ds[3] = 5;
    tentativa("lock1", 4, ds, 1'b0);
    tentativa("lock2", 4, ds, 1'b0);
    tentativa("lock3", 4, ds, 1'b0);
    chk("lock.tent_max", tentativas, 3);
    ds[3] = 4;
    tentativa("lock_after", 4, ds, 1'b0);

    // Test 4: short code fails in one cycle; a fifth digit is dropped.
    do_reset();
    ds[0] = 1; ds[1] = 2;
    tentativa("short", 2, ds, 1'b0);
    ds[0] = 1; ds[1] = 2; ds[2] = 3; ds[3] = 4; ds[4] = 9;
    tentativa("overflow", 5, ds, 1'b0);

    // Test 5: digit 4 collides with confirma at count 3 -> short code.
    do_reset();
    ds[0] = 1; ds[1] = 2; ds[2] = 3; ds[3] = 4;
    tentativa("collision", 4, ds, 1'b1);

    // Test 6: reset during the second compare cycle, then a clean correct entry.
    do_reset();
    for (int i = 0; i < N; i++) entra(4'(i + 1));
    confirma = 1'b1;
    step();
    confirma = 1'b0;
    step();
    chk("rstmid.in_compare", en_cmp, 1'b1);
    chk("rstmid.q1_second", q1, 2);
    do_reset();
    chk("rstmid.estado", estado, CAPTURA);
    chk("rstmid.outs", {q1, q2, en_cmp, digitos_lidos, tentativas, erro, acerto, bloqueado}, '0);
    tentativa("rstmid.fresh", 4, ds, 1'b0);

    // Randomized attempts against the model, new reference code per reset.
    for (int it = 0; it < 25; it++) begin
      senha_ref = 16'($urandom_range(0, 16'hFFFF));
      do_reset();
      for (int a = 0; a < 5; a++) begin
        int  len;
        bit  col;
        len = $urandom_range(0, N + 1);
        for (int j = 0; j < 8; j++) begin
          if (j < N && $urandom_range(0, 3) != 0) ds[j] = 4'(ref_dig(j));
          else ds[j] = 4'($urandom_range(0, 15));
        end
        col = (len > 0) && ($urandom_range(0, 3) == 0);
        tentativa($sformatf("rnd%0d_%0d", it, a), len, ds, col);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
